// File: rtl/msg_rate_scheduler_pkg.sv
// rtl/msg_rate_scheduler_pkg.sv - shared types and helpers for the message rate scheduler
package msg_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_t;

  localparam int MAX_REQ = 8;

  function automatic int slot_len(input int clk_hz, input int rate);
    return clk_hz / rate;
  endfunction

  // First set bit of valid searching pnt, pnt+1, ... wrapping at num_req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0] pnt,
                                         input int num_req);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(pnt) + k;
      if (idx >= num_req) idx = idx - num_req;
      if (k < num_req && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/msg_rate_scheduler_if.sv
// rtl/msg_rate_scheduler_if.sv - requester and transmitter signals of the message rate scheduler
interface msg_rate_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int SRC_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_valid;
  logic [DATA_W-1:0]         tx_data;
  logic [SRC_W-1:0]          tx_src;
  logic                      tx_ready;
  logic                      slot_tick;
  logic                      busy;

  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, tx_src, slot_tick, busy
  );

  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_src, slot_tick, busy
  );

endinterface

// File: rtl/msg_rate_scheduler_rate_tick_gen.sv
// rtl/msg_rate_scheduler_rate_tick_gen.sv - free-running slot timer producing a one-cycle strobe
module rate_tick_gen
  import msg_sched_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int MESSAGE_RATE = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int SLOT_LEN = slot_len(CLK_HZ, MESSAGE_RATE);
  localparam int CNT_W    = (SLOT_LEN > 2) ? $clog2(SLOT_LEN) : 1;

  if (SLOT_LEN < 2) begin : g_bad_slot
    $error("rate_tick_gen: CLK_HZ / MESSAGE_RATE must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_LEN - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/msg_rate_scheduler.sv
// rtl/msg_rate_scheduler.sv - paces requester messages onto one transmitter, one per rate slot
module msg_rate_scheduler
  import msg_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_HZ       = 50000000,
  parameter int MESSAGE_RATE = 9600,
  parameter int DATA_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  msg_rate_scheduler_if.master bus
);
  localparam int SRC_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("msg_rate_scheduler: NUM_REQ must be in 2..8");
  end

  sched_state_t         state;
  logic [SRC_W-1:0]     pnt;
  logic [SRC_W-1:0]     winner;
  logic [SRC_W-1:0]     next_pnt;
  logic [SRC_W-1:0]     tx_src;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_valid;
  logic                 busy;
  logic                 tick;
  logic                 grant;
  logic [2:0]           pick;
  logic [MAX_REQ-1:0]   valid_ext;
  logic [NUM_REQ-1:0]   req_ready;

  rate_tick_gen #(
    .CLK_HZ      (CLK_HZ),
    .MESSAGE_RATE(MESSAGE_RATE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Grants are only issued from IDLE on a tick, so ticks seen in SEND are simply lost.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = bus.req_valid;
    pick                     = rr_pick(valid_ext, 3'(pnt), NUM_REQ);
    winner                   = pick[SRC_W-1:0];
    grant                    = (state == IDLE) && tick && (|bus.req_valid);
    req_ready                = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign next_pnt = (tx_src == SRC_W'(NUM_REQ - 1)) ? '0 : tx_src + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pnt      <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      tx_data  <= '0;
      tx_src   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            tx_data  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
            tx_src   <= winner;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // Pointer moves only on a completed send, which keeps the rotation fair.
          if (bus.tx_ready) begin
            pnt      <= next_pnt;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.tx_src    = tx_src;
  assign bus.busy      = busy;
  assign bus.slot_tick = tick;

endmodule

// File: tb/tb_msg_rate_scheduler.sv
// tb/tb_msg_rate_scheduler.sv - scoreboard bench for msg_rate_scheduler against a slot-level reference model
module tb_msg_rate_scheduler;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int SL = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_rate_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  logic [DW-1:0] dat [NR];
  assign bus.req_data = {dat[3], dat[2], dat[1], dat[0]};

  msg_rate_scheduler #(
    .NUM_REQ     (NR),
    .CLK_HZ      (1000),
    .MESSAGE_RATE(100),
    .DATA_W      (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int src;
    int data;
    int gcyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index since reset release decides ticks; one grant per idle tick.
  int mc;
  bit m_busy;
  int m_pnt;
  int m_src;
  bit tick_e;
  bit nb;
  int exp_rdy;
  int w;

  always @(negedge clk) begin
    if (rst) begin
      mc     = 0;
      m_busy = 1'b0;
      m_pnt  = 0;
      m_src  = 0;
      sbq.delete();
    end else begin
      tick_e = ((mc % SL) == SL - 1);
      chk("slot_tick", int'(bus.slot_tick), int'(tick_e));
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("tx_valid", int'(bus.tx_valid), int'(m_busy));
      exp_rdy = 0;
      nb      = m_busy;
      if (!m_busy && tick_e && bus.req_valid != '0) begin
        w = -1;
        for (int k = 0; k < NR; k++)
          if (w < 0 && bus.req_valid[(m_pnt + k) % NR]) w = (m_pnt + k) % NR;
        exp_rdy = 1 << w;
        sbq.push_back('{w, int'(bus.req_data[w*DW +: DW]), mc});
        m_src = w;
        nb    = 1'b1;
      end else if (m_busy && bus.tx_ready) begin
        m_pnt = (m_src + 1) % NR;
        nb    = 1'b0;
      end
      chk("req_ready", int'(bus.req_ready), exp_rdy);
      m_busy = nb;
      mc++;
    end
  end

  int oc;
  bit prev_v;

  always @(negedge clk) begin
    if (rst) begin
      oc     = 0;
      prev_v = 1'b0;
    end else begin
      if (bus.tx_valid) begin
        if (sbq.size() == 0) begin
          chk("tx_valid_unexpected", int'(bus.tx_valid), 0);
        end else begin
          chk("tx_data", int'(bus.tx_data), sbq[0].data);
          chk("tx_src", int'(bus.tx_src), sbq[0].src);
          if (!prev_v) chk("tx_latency", oc, sbq[0].gcyc + 1);
          if (bus.tx_ready) void'(sbq.pop_front());
        end
      end
      prev_v = bus.tx_valid;
      oc++;
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_txv();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.tx_valid) ok = 1'b1;
    end
    if (!ok) chk("wait_tx_valid", int'(bus.tx_valid), 1);
  endtask

  logic [NR-1:0] rdy_seen;

  initial begin
    bus.req_valid = '0;
    bus.tx_ready  = 1'b1;
    for (int i = 0; i < NR; i++) dat[i] = '0;

    // single requester
    dat[0] = 8'hA5;
    bus.req_valid = 4'b0001;
    do_reset();
    run(45);

    // all four continuously valid
    for (int i = 0; i < NR; i++) dat[i] = 8'(8'h10 + i);
    bus.req_valid = 4'b1111;
    do_reset();
    run(60);

    // sparse requesters 1 and 3
    for (int i = 0; i < NR; i++) dat[i] = 8'($urandom);
    bus.req_valid = 4'b1010;
    do_reset();
    run(50);

    // transmitter stall spanning two ticks
    for (int i = 0; i < NR; i++) dat[i] = 8'(8'h20 + i);
    bus.req_valid = 4'b1111;
    bus.tx_ready  = 1'b0;
    do_reset();
    wait_txv();
    run(25);
    bus.tx_ready = 1'b1;
    run(40);

    // request arriving mid-slot
    bus.req_valid = '0;
    dat[2] = 8'h5C;
    do_reset();
    repeat (3) @(posedge clk);
    #1 bus.req_valid = 4'b0100;
    run(30);

    // asynchronous reset while a message is pending
    for (int i = 0; i < NR; i++) dat[i] = 8'(8'h30 + i);
    bus.req_valid = 4'b1111;
    bus.tx_ready  = 1'b0;
    do_reset();
    wait_txv();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", int'(bus.tx_valid), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_req_ready", int'(bus.req_ready), 0);
    chk("async_rst_tx_data", int'(bus.tx_data), 0);
    bus.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run(30);

    // randomized requesters and transmitter backpressure
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rdy_seen = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (rdy_seen[i] || (bus.req_valid[i] && $urandom_range(0, 15) == 0)) begin
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          dat[i] = 8'($urandom);
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.tx_ready = ($urandom_range(0, 3) != 0);
    end

    bus.req_valid = '0;
    bus.tx_ready  = 1'b1;
    run(30);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
